wave_meter: RTL
===============

# wave_meter

Measurement block for the DDS output path. It consumes the 8-bit unsigned sample stream produced by the wave generator. For each waveform period it reports the period length in clock cycles and the peak and trough sample values. It is used in closed-loop self-test of `freq_ctl` and `wave_selector` settings, and as the on-board frequency readout.

## Interface
- `CNT_W`, 16: width of the period counter and of `period`.
- `HYST`, 8: hysteresis around mid-scale 128. The upper threshold is `128+HYST` and the lower threshold is `128-HYST`. Legal range is 1..100.

Ports:
- `clk`  in  1: single system clock. Samples are taken once per cycle.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `sample_in`  in  8: unsigned wave sample, the `output_wave` of the generator.
- `enable`  in  1: when low, the meter is held in SEEK and its outputs are frozen.
- `period`  out  CNT_W: last measured period in clock cycles.
- `vmax`  out  8: maximum sample seen within the last period.
- `vmin`  out  8: minimum sample seen within the last period.
- `meas_valid`  out  1: one-cycle pulse that marks when `period`, `vmax` and `vmin` have updated.
- `timeout`  out  1: sticky flag for "no crossing within 2^CNT_W−1 cycles". It is cleared by the next valid measurement.

## Operation
- **Input stage:** `sample_in` is registered into `s1`, and all logic below uses `s1`.
- **Hysteresis comparator `cmp`:**
  - Set when `s1 >= 128+HYST`.
  - Cleared when `s1 <= 128-HYST`.
  - Otherwise holds its value.
  - Reset value is 0.
- **Rising event `rise`:** asserted when `cmp` goes from 0 to 1, i.e. when the registered value of `cmp` differs from its previous value in the 0→1 direction.
- **FSM states:**
  - SEEK: waits for `cmp==0`, which guarantees a known low phase, then moves to ARM. If `s1` stays between the thresholds, SEEK persists.
  - ARM: waits for `rise`. On `rise`, it clears `cnt` to 1, sets the trackers `mx` and `mn` to `s1`, and moves to MEAS.
  - MEAS: on each cycle without `rise`, `cnt` increments and `mx`/`mn` track `s1`. On `rise`, it latches the outputs (`period=cnt`, `vmax=mx`, `vmin=mn`), pulses `meas_valid`, clears `timeout`, restarts `cnt` at 1 with the trackers set to `s1`, and stays in MEAS.
  - Timeout: in ARM or MEAS, if `cnt` or the wait counter reaches 2^CNT_W−1 without `rise`:
    - `timeout` is set.
    - `period` is set to all-ones, `vmax` and `vmin` are set to the tracker values, and `meas_valid` pulses.
    - The FSM moves to SEEK.
- **Enable:** when `enable` is low, the FSM goes to SEEK and the counters are cleared. The output registers keep their values.
- **Arithmetic:** `cnt` is unsigned CNT_W bits and saturates at all-ones; it never wraps. Tracker comparisons are unsigned 8-bit.
- **Simultaneous events:** if a `rise` arrives in the same cycle that `cnt` reaches all-ones, the `rise` wins. That cycle produces a normal measurement with `period` = all-ones and no `timeout`.

## Timing
- **Reset values:** `period=0`, `vmax=0`, `vmin=0`, `meas_valid=0`, `timeout=0`. Internally, state=SEEK, `cmp=0`, `cnt=0`.
- **Measurement latency:** if the crossing sample is presented on `sample_in` before clock edge k, `meas_valid` is high during the cycle after edge k+2, and the outputs are stable from that same edge.
- **Period accuracy:** `period` equals the exact number of input samples between two consecutive qualified rising crossings.
- **First pulse:** the first `meas_valid` after reset or after SEEK needs two rising crossings.
- **Reset mid-measurement:** `rst_n` low at any edge returns everything to the reset values on that edge. No pulse is emitted.
- **Handshake:** none. `meas_valid` is a strobe. Consumers must sample it on the cycle it is high; it is never held.

## Configuration
- Macro: `WAVE_METER_AVG_EN`.
- **Defined:** the meter accumulates 4 consecutive periods in a (CNT_W+2)-bit sum.
  - `period` is the sum >> 2, truncated.
  - `vmax` is the maximum over the 4 periods and `vmin` is the minimum over the 4 periods.
  - `meas_valid` pulses once per 4 periods, on the 4th `rise`.
  - A timeout or SEEK discards the partial accumulation.
- **Undefined:** the meter reports every period, as described above.

## Test plan
- **Square wave:** `sample_in` alternates 10 cycles of 0 and 10 cycles of 255.
  - Without the macro: `meas_valid` every 20 cycles, with `period=20`, `vmax=255`, `vmin=0`.
  - With the macro: pulse every 80 cycles, with `period=20`.
- **Noise rejection, HYST=8:** a ramp 0→255 over 64 cycles, with ±6 LSB dither around 128. Required response: exactly one `rise` per ramp, `period=64`, `vmax=255`, `vmin=0`.
- **Timeout, CNT_W=8:** `sample_in` held constant at 200 after one valid crossing. Required response: `timeout=1` and `period=255` after 255 cycles, a single `meas_valid`, and the FSM in SEEK.
- **Reset mid-period:** `rst_n=0` for 1 cycle in the middle of MEAS. Required response: all outputs 0 on the next edge, and the next `meas_valid` only after two new crossings.
- **DDS loop:** drive the generator with `wave_selector=2'b11`, `freq_ctl=12'd4`, and feed its output to `sample_in`. Required response: `period` is constant across 3 consecutive pulses and matches the generator period computed from `freq_ctl`, with `timeout` remaining 0.

Source files
------------

// File: rtl/wave_meter.sv
`default_nettype none
// ============================================================================
// Module      : wave_meter
// Description : Period / peak / trough meter for the 8-bit DDS sample stream.
//               A hysteresis comparator around mid-scale qualifies rising
//               crossings; the span between two crossings is one period.
//               Optional macro WAVE_METER_AVG_EN averages 4 periods per report.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_meter #(
  parameter int CNT_W = 16,
  parameter int HYST  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       sample_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [7:0]       vmax,
  output logic [7:0]       vmin,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [7:0]       HI_TH   = 8'(128 + HYST);
  localparam logic [7:0]       LO_TH   = 8'(128 - HYST);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       s1;
  logic             cmp, cmp_q;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       mx, mn;
  logic             do_start, do_meas, do_tout, do_count;

  // Input register plus hysteresis comparator and its one-cycle history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 8'd0;
      cmp   <= 1'b0;
      cmp_q <= 1'b0;
    end else begin
      s1 <= sample_in;
      if (s1 >= HI_TH)      cmp <= 1'b1;
      else if (s1 <= LO_TH) cmp <= 1'b0;
      cmp_q <= cmp;
    end
  end

  assign rise = cmp & ~cmp_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= SEEK;
    else        state <= state_nxt;
  end

  // Next state and datapath strobes; a rise always beats a saturated counter
  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_meas   = 1'b0;
    do_tout   = 1'b0;
    do_count  = 1'b0;
    if (!enable) begin
      state_nxt = SEEK;
    end else begin
      case (state)
        SEEK: if (!cmp) state_nxt = ARM;
        ARM: begin
          if (rise) begin
            do_start  = 1'b1;
            state_nxt = MEAS;
          end else if (cnt == CNT_MAX) begin
            do_tout   = 1'b1;
            state_nxt = SEEK;
          end else begin
            do_count = 1'b1;
          end
        end
        MEAS: begin
          if (rise) begin
            do_meas = 1'b1;
          end else if (cnt == CNT_MAX) begin
            do_tout   = 1'b1;
            state_nxt = SEEK;
          end else begin
            do_count = 1'b1;
          end
        end
        default: state_nxt = SEEK;
      endcase
    end
  end

`ifdef WAVE_METER_AVG_EN
  logic [CNT_W+1:0] acc;
  logic [1:0]       acc_n;
  logic [7:0]       acc_mx, acc_mn;
  logic [CNT_W+1:0] acc_sum;
  logic [7:0]       blk_mx, blk_mn;

  // Running sum and extremes including the period that is closing now
  always_comb begin
    acc_sum = acc + {2'b00, cnt};
    blk_mx  = (acc_n == 2'd0 || mx > acc_mx) ? mx : acc_mx;
    blk_mn  = (acc_n == 2'd0 || mn < acc_mn) ? mn : acc_mn;
  end
`endif

  // Counter, trackers and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      mx         <= 8'd0;
      mn         <= 8'd0;
      period     <= '0;
      vmax       <= 8'd0;
      vmin       <= 8'd0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
`ifdef WAVE_METER_AVG_EN
      acc        <= '0;
      acc_n      <= 2'd0;
      acc_mx     <= 8'd0;
      acc_mn     <= 8'd0;
`endif
    end else begin
      meas_valid <= 1'b0;
      if (!enable || state == SEEK) cnt <= '0;
`ifdef WAVE_METER_AVG_EN
      // A partial 4-period block never survives leaving MEAS
      if (state != MEAS || do_tout) begin
        acc   <= '0;
        acc_n <= 2'd0;
      end
`endif
      if (do_count) begin
        cnt <= cnt + CNT_ONE;
        if (state == MEAS) begin
          if (s1 > mx) mx <= s1;
          if (s1 < mn) mn <= s1;
        end
      end
      if (do_start || do_meas) begin
        cnt <= CNT_ONE;
        mx  <= s1;
        mn  <= s1;
      end
      if (do_meas) begin
`ifdef WAVE_METER_AVG_EN
        if (acc_n == 2'd3) begin
          period     <= acc_sum[CNT_W+1:2];
          vmax       <= blk_mx;
          vmin       <= blk_mn;
          meas_valid <= 1'b1;
          timeout    <= 1'b0;
          acc        <= '0;
          acc_n      <= 2'd0;
        end else begin
          acc    <= acc_sum;
          acc_mx <= blk_mx;
          acc_mn <= blk_mn;
          acc_n  <= acc_n + 2'd1;
        end
`else
        period     <= cnt;
        vmax       <= mx;
        vmin       <= mn;
        meas_valid <= 1'b1;
        timeout    <= 1'b0;
`endif
      end
      if (do_tout) begin
        cnt        <= '0;
        period     <= CNT_MAX;
        vmax       <= mx;
        vmin       <= mn;
        meas_valid <= 1'b1;
        timeout    <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
